// File: rtl/r2b_tile_scheduler.sv
// Tile sequencer for one r2b_converter_h: arms the converter, streams ROW input rows,
// then frames converter output beats into MAC slices with first/last markers.
module r2b_tile_scheduler #(
  parameter int unsigned ROW         = 256,
  parameter int unsigned COL         = 64,
  parameter int unsigned BLOCK_SIZE  = 2,
  parameter int unsigned NUM_CORES_H = 1,
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned TIMEOUT     = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              cnv_en,
  output logic              cnv_in_valid,
  output logic              cnv_soft_rst,
  input  logic              cnv_output_ready,
  input  logic              cnv_slice_done,
  input  logic              cnv_buffer_done,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_count
);

  localparam int unsigned BEATS_PER_SLICE = ROW / BLOCK_SIZE;
  localparam int unsigned SLICES          = COL / (BLOCK_SIZE * NUM_CORES_H);
  localparam int unsigned TOTAL_BEATS     = BEATS_PER_SLICE * SLICES;

  localparam int unsigned RW = $clog2(ROW + 1);
  localparam int unsigned BW = $clog2(BEATS_PER_SLICE + 1);
  localparam int unsigned SW = $clog2(SLICES + 1);
  localparam int unsigned TW = $clog2(TOTAL_BEATS + 2);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROW - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_SLICE - 1);
  localparam logic [TW-1:0] TOT_FULL  = TW'(TOTAL_BEATS);
  localparam logic [TW-1:0] TOT_SAT   = TW'(TOTAL_BEATS + 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [SW-1:0]     slice_cnt_q, slice_cnt_d;
  logic [TW-1:0]     tot_cnt_q, tot_cnt_d;
  logic [WW-1:0]     wd_cnt_q, wd_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_count_q, err_count_d;

  // Slice boundaries are derived from our own beat count; the converter flag is informational.
  logic unused_slice_done;
  assign unused_slice_done = cnv_slice_done;

  assign busy         = (state_q != S_IDLE);
  assign src_ready    = (state_q == S_FILL);
  assign cnv_en       = (state_q == S_ARM);
  assign cnv_in_valid = src_valid & src_ready;
  assign cnv_soft_rst = abort & busy;
  assign mac_valid    = (state_q == S_DRAIN) & cnv_output_ready;
  assign mac_first    = mac_valid & (beat_cnt_q == '0);
  assign mac_last     = mac_valid & (beat_cnt_q == BEAT_LAST);
  assign done         = (state_q == S_DONE);
  assign err_timeout  = err_timeout_q;
  assign err_count    = err_count_q;

  always_comb begin
    state_d       = state_q;
    num_tiles_d   = num_tiles_q;
    tile_cnt_d    = tile_cnt_q;
    row_cnt_d     = row_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    slice_cnt_d   = slice_cnt_q;
    tot_cnt_d     = tot_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    err_timeout_d = err_timeout_q;
    err_count_d   = err_count_q;

    if (busy && abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            err_timeout_d = 1'b0;
            err_count_d   = 1'b0;
            if (num_tiles != '0) begin
              num_tiles_d = num_tiles;
              tile_cnt_d  = '0;
              state_d     = S_ARM;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_ARM: begin
          row_cnt_d   = '0;
          beat_cnt_d  = '0;
          slice_cnt_d = '0;
          tot_cnt_d   = '0;
          wd_cnt_d    = '0;
          state_d     = S_FILL;
        end
        S_FILL: begin
          if (cnv_in_valid) begin
            row_cnt_d = row_cnt_q + 1'b1;
            if (row_cnt_q == ROW_LAST) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (mac_valid) begin
            if (beat_cnt_q == BEAT_LAST) begin
              beat_cnt_d  = '0;
              slice_cnt_d = slice_cnt_q + 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (tot_cnt_q != TOT_SAT) tot_cnt_d = tot_cnt_q + 1'b1;
          end
          // tot_cnt_d already includes a beat landing together with buffer_done.
          if (cnv_buffer_done) begin
            if (tot_cnt_d != TOT_FULL) err_count_d = 1'b1;
            tile_cnt_d = tile_cnt_q + 1'b1;
            state_d    = (tile_cnt_q == num_tiles_q - 1'b1) ? S_DONE : S_ARM;
          end else if (wd_cnt_q == WD_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      num_tiles_q   <= '0;
      tile_cnt_q    <= '0;
      row_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      slice_cnt_q   <= '0;
      tot_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_tiles_q   <= num_tiles_d;
      tile_cnt_q    <= tile_cnt_d;
      row_cnt_q     <= row_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      slice_cnt_q   <= slice_cnt_d;
      tot_cnt_q     <= tot_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

endmodule
